// File: rtl/fifo_pkg.sv
// Shared types for the serial-to-parallel FIFO packer.
// Holds the packer state encoding used by fifo_packer.
package fifo_pkg;

    typedef enum logic {
        FILL = 1'b0,
        SEND = 1'b1
    } packer_state_t;

endpackage

// File: rtl/fifo_packer.sv
// Purpose: packs serial words into PAR_WRITE-lane groups for a FIFO write port (lane 0 = oldest).
// Latency: group presented the cycle after its last word is accepted; one group per PAR_WRITE+1 cycles.
// Backpressure: in_ready drops while a group waits; wr_ready low holds data_out/fill_count indefinitely.
// Optional: define FIFO_PACKER_FLUSH_EN to let flush emit a partial group.
module fifo_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PAR_WRITE  = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             flush,
    output logic [DATA_WIDTH-1:0]            data_out [PAR_WRITE],
    output logic                             wr_req,
    input  logic                             wr_ready,
    output logic [$clog2(PAR_WRITE+1)-1:0]   fill_count
);

    localparam int            CW       = $clog2(PAR_WRITE + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(PAR_WRITE);

    packer_state_t         state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] lane_q [PAR_WRITE];
    logic                  accept;
    logic                  transfer;
    logic                  flush_go;

`ifdef FIFO_PACKER_FLUSH_EN
    assign flush_go = flush;
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign flush_go     = 1'b0;
`endif

    // A word arriving together with flush is counted first, so the flushed group includes it.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        in_ready = 1'b0;
        wr_req   = 1'b0;
        accept   = 1'b0;
        transfer = 1'b0;
        case (state_q)
            FILL: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (accept) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (cnt_d == CNT_FULL) begin
                    state_d = SEND;
                end else if (flush_go && (cnt_d != '0)) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                wr_req   = 1'b1;
                transfer = wr_ready;
                if (transfer) begin
                    state_d = FILL;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = FILL;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Lanes are zeroed after every transfer so unwritten lanes of a partial group read 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PAR_WRITE; i++) begin
                lane_q[i] <= '0;
            end
        end else if (transfer) begin
            for (int i = 0; i < PAR_WRITE; i++) begin
                lane_q[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < PAR_WRITE; i++) begin
                if (cnt_q == CW'(i)) begin
                    lane_q[i] <= in_data;
                end
            end
        end
    end

    assign data_out   = lane_q;
    assign fill_count = cnt_q;

endmodule

// File: tb/tb_fifo_packer.sv
// Scoreboard bench for fifo_packer: a PAR_WRITE=4 instance and a PAR_WRITE=1 instance.
// Expected groups are queued by the stimulus and popped by per-instance monitors on each transfer.
module tb_fifo_packer;

    logic clk;
    logic rst;

    logic [7:0] in_data4;
    logic       in_valid4, in_ready4, flush4, wr_req4, wr_ready4;
    logic [7:0] dout4 [4];
    logic [2:0] fc4;

    logic [7:0] in_data1;
    logic       in_valid1, in_ready1, flush1, wr_req1, wr_ready1;
    logic [7:0] dout1 [1];
    logic [0:0] fc1;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] lanes;
        logic [2:0]  cnt;
    } grp_t;

    grp_t        q4[$];
    logic [7:0]  q1[$];

    fifo_packer #(.DATA_WIDTH(8), .PAR_WRITE(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
        .flush(flush4), .data_out(dout4), .wr_req(wr_req4),
        .wr_ready(wr_ready4), .fill_count(fc4)
    );

    fifo_packer #(.DATA_WIDTH(8), .PAR_WRITE(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .flush(flush1), .data_out(dout1), .wr_req(wr_req1),
        .wr_ready(wr_ready1), .fill_count(fc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp4(input logic [7:0] a, b, c, d, input logic [2:0] n);
        grp_t g;
        g.lanes = {d, c, b, a};
        g.cnt   = n;
        q4.push_back(g);
    endtask

    always @(negedge clk) begin
        if (rst && wr_req4 && wr_ready4) begin
            if (q4.size() == 0) begin
                total++;
                bad++;
                $display("FAIL p4_unexpected_group: got wr_req=1 expected no group");
            end else begin
                grp_t g;
                g = q4.pop_front();
                for (int i = 0; i < 4; i++) begin
                    chk($sformatf("p4_lane%0d", i), {24'h0, dout4[i]}, {24'h0, g.lanes[i*8 +: 8]});
                end
                chk("p4_fill_count", {29'h0, fc4}, {29'h0, g.cnt});
            end
        end
    end

    always @(negedge clk) begin
        if (rst && wr_req1 && wr_ready1) begin
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL p1_unexpected_group: got wr_req=1 expected no group");
            end else begin
                logic [7:0] w;
                w = q1.pop_front();
                chk("p1_lane0", {24'h0, dout1[0]}, {24'h0, w});
                chk("p1_fill_count", {31'h0, fc1}, 32'd1);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send4(input logic [7:0] w);
        int b = 0;
        in_valid4 = 1'b1;
        in_data4  = w;
        while (!in_ready4 && b < 50) begin
            cyc();
            b++;
        end
        if (b >= 50) chk("p4_in_ready_timeout", 32'd0, 32'd1);
        cyc();
        in_valid4 = 1'b0;
    endtask

    task automatic drain();
        int b = 0;
        while ((q4.size() != 0 || q1.size() != 0) && b < 100) begin
            cyc();
            b++;
        end
        chk("drain_q4_empty", q4.size(), 32'd0);
        chk("drain_q1_empty", q1.size(), 32'd0);
    endtask

    initial begin
        logic       exp_rdy;
        int         k;
        logic [7:0] words [6];
        words = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};

        rst = 1'b1;
        in_data4 = 8'h0; in_valid4 = 1'b0; flush4 = 1'b0; wr_ready4 = 1'b1;
        in_data1 = 8'h0; in_valid1 = 1'b0; flush1 = 1'b0; wr_ready1 = 1'b1;
        #3 rst = 1'b0;
        #9;
        chk("rst_wr_req", {31'h0, wr_req4}, 32'd0);
        chk("rst_in_ready", {31'h0, in_ready4}, 32'd1);
        chk("rst_fill_count", {29'h0, fc4}, 32'd0);
        chk("rst_lane0", {24'h0, dout4[0]}, 32'd0);
        chk("rst_lane3", {24'h0, dout4[3]}, 32'd0);
        chk("rst_p1_in_ready", {31'h0, in_ready1}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        cyc();

        // back-to-back full group, FIFO always ready
        exp4(8'h11, 8'h22, 8'h33, 8'h44, 3'd4);
        send4(8'h11); send4(8'h22); send4(8'h33); send4(8'h44);
        chk("full_wr_req", {31'h0, wr_req4}, 32'd1);
        chk("full_in_ready", {31'h0, in_ready4}, 32'd0);
        chk("full_fill_count", {29'h0, fc4}, 32'd4);
        cyc();
        chk("after_xfer_wr_req", {31'h0, wr_req4}, 32'd0);
        chk("after_xfer_fill", {29'h0, fc4}, 32'd0);
        chk("after_xfer_lane0_clear", {24'h0, dout4[0]}, 32'd0);

        // held group under backpressure, extra offers ignored
        wr_ready4 = 1'b0;
        exp4(8'h55, 8'h66, 8'h77, 8'h88, 3'd4);
        send4(8'h55); send4(8'h66); send4(8'h77); send4(8'h88);
        in_valid4 = 1'b1;
        in_data4  = 8'hEE;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) wr_ready4 = 1'b1;
            chk($sformatf("hold%0d_wr_req", c), {31'h0, wr_req4}, 32'd1);
            chk($sformatf("hold%0d_lane3", c), {24'h0, dout4[3]}, 32'h88);
            chk($sformatf("hold%0d_fill", c), {29'h0, fc4}, 32'd4);
            cyc();
        end
        in_valid4 = 1'b0;
        chk("hold_done_wr_req", {31'h0, wr_req4}, 32'd0);
        chk("hold_extra_not_taken", {29'h0, fc4}, 32'd0);

        // partial group then flush
        send4(8'hA1); send4(8'hA2);
`ifdef FIFO_PACKER_FLUSH_EN
        exp4(8'hA1, 8'hA2, 8'h00, 8'h00, 3'd2);
        flush4 = 1'b1;
        cyc();
        flush4 = 1'b0;
        chk("flush_wr_req", {31'h0, wr_req4}, 32'd1);
        chk("flush_fill", {29'h0, fc4}, 32'd2);
        chk("flush_lane2_zero", {24'h0, dout4[2]}, 32'd0);
        cyc();
        // word and flush together: the word joins the flushed group
        exp4(8'hC1, 8'hC2, 8'h00, 8'h00, 3'd2);
        send4(8'hC1);
        in_valid4 = 1'b1; in_data4 = 8'hC2; flush4 = 1'b1;
        cyc();
        in_valid4 = 1'b0; flush4 = 1'b0;
        chk("flush_with_word_fill", {29'h0, fc4}, 32'd2);
        cyc();
`else
        flush4 = 1'b1;
        cyc();
        flush4 = 1'b0;
        chk("noflush_wr_req", {31'h0, wr_req4}, 32'd0);
        chk("noflush_fill", {29'h0, fc4}, 32'd2);
        exp4(8'hA1, 8'hA2, 8'hB3, 8'hB4, 3'd4);
        send4(8'hB3); send4(8'hB4);
        chk("noflush_full_wr_req", {31'h0, wr_req4}, 32'd1);
        cyc();
`endif
        flush4 = 1'b1;
        cyc();
        flush4 = 1'b0;
        chk("flush_empty_wr_req", {31'h0, wr_req4}, 32'd0);
        cyc();
        chk("flush_empty_wr_req2", {31'h0, wr_req4}, 32'd0);

        // asynchronous reset while a group is pending
        wr_ready4 = 1'b0;
        send4(8'hD1); send4(8'hD2); send4(8'hD3); send4(8'hD4);
        chk("pre_rst_wr_req", {31'h0, wr_req4}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_wr_req", {31'h0, wr_req4}, 32'd0);
        chk("async_rst_fill", {29'h0, fc4}, 32'd0);
        chk("async_rst_lane0", {24'h0, dout4[0]}, 32'd0);
        chk("async_rst_lane3", {24'h0, dout4[3]}, 32'd0);
        chk("async_rst_in_ready", {31'h0, in_ready4}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        wr_ready4 = 1'b1;
        cyc(); cyc(); cyc();
        chk("post_rst_no_group", {31'h0, wr_req4}, 32'd0);
        exp4(8'hE1, 8'hE2, 8'hE3, 8'hE4, 3'd4);
        send4(8'hE1); send4(8'hE2); send4(8'hE3); send4(8'hE4);
        cyc();

        // single-lane instance under continuous in_valid
        exp_rdy   = 1'b1;
        k         = 0;
        in_valid1 = 1'b1;
        in_data1  = words[0];
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("p1_in_ready_c%0d", c), {31'h0, in_ready1}, {31'h0, exp_rdy});
            if (in_ready1 && k < 6) begin
                in_data1 = words[k];
                q1.push_back(words[k]);
                k++;
            end else if (!in_ready1 && k == 6) begin
                in_valid1 = 1'b0;
            end
            exp_rdy = ~exp_rdy;
            cyc();
        end
        in_valid1 = 1'b0;
        cyc();

        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
